// File: rtl/hash_display_scanner_if.sv
// Signal bundle between the SHA-256 result/board controls and the
// seven-segment scanner; slave is the scanner side, master the driving side.
interface hash_display_scanner_if #(
  parameter int HASH_WIDTH = 256,
  parameter int NUM_DIGITS = 8
);
  localparam int NUM_PAGES = HASH_WIDTH / (4 * NUM_DIGITS);
  localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

  logic                  finished;
  logic [HASH_WIDTH-1:0] hash_value;
  logic                  mode;
  logic                  page_next;
  logic                  page_prev;
  logic [6:0]            seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic                  done_LED;
  logic                  match_LED;
  logic [PAGE_W-1:0]     page;

  modport slave (
    input  finished, hash_value, mode, page_next, page_prev,
    output seg_n, an_n, done_LED, match_LED, page
  );

  modport master (
    output finished, hash_value, mode, page_next, page_prev,
    input  seg_n, an_n, done_LED, match_LED, page
  );
endinterface

// File: rtl/hash_display_scanner.sv
// Latches the SHA-256 digest on the first finished pulse and scans it onto
// common-anode seven-segment digits as a PASS/FAIL verdict or a paged hex dump.
module hash_display_scanner #(
  parameter int                    NUM_DIGITS    = 8,
  parameter int                    HASH_WIDTH    = 256,
  parameter int                    SCAN_DIV      = 18,
  parameter logic [HASH_WIDTH-1:0] EXPECTED_HASH =
    256'hB94D27B9934D3E08A52E52D7DA7DABFAC484EFE37A5380EE9088F7ACE2EFCDE9
) (
  input logic clock,
  input logic reset,
  hash_display_scanner_if.slave bus
);
  localparam int NUM_PAGES = HASH_WIDTH / (4 * NUM_DIGITS);
  localparam int PAGE_W    = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;
  localparam int DIG_W     = $clog2(NUM_DIGITS);
  localparam int NIB_W     = $clog2(HASH_WIDTH / 4);

  // Glyphs as lit-segment patterns {a,b,c,d,e,f,g}; inverted at the pin.
  localparam logic [6:0] LIT_P = 7'b1100111;
  localparam logic [6:0] LIT_A = 7'b1110111;
  localparam logic [6:0] LIT_S = 7'b1011011;
  localparam logic [6:0] LIT_F = 7'b1000111;
  localparam logic [6:0] LIT_I = 7'b0000110;
  localparam logic [6:0] LIT_L = 7'b0001110;

  function automatic logic [6:0] hex_font(input logic [3:0] v);
    logic [6:0] lit;
    case (v)
      4'h0: lit = 7'b1111110;
      4'h1: lit = 7'b0110000;
      4'h2: lit = 7'b1101101;
      4'h3: lit = 7'b1111001;
      4'h4: lit = 7'b0110011;
      4'h5: lit = 7'b1011011;
      4'h6: lit = 7'b1011111;
      4'h7: lit = 7'b1110000;
      4'h8: lit = 7'b1111111;
      4'h9: lit = 7'b1111011;
      4'hA: lit = 7'b1110111;
      4'hB: lit = 7'b0011111;
      4'hC: lit = 7'b1001110;
      4'hD: lit = 7'b0111101;
      4'hE: lit = 7'b1001111;
      default: lit = 7'b1000111;
    endcase
    return lit;
  endfunction

  logic [SCAN_DIV-1:0]   scan_cnt_q, scan_cnt_d;
  logic [DIG_W-1:0]      digit_idx_q, digit_idx_d;
  logic                  done_q, done_d;
  logic                  match_q, match_d;
  logic [HASH_WIDTH-1:0] hash_q, hash_d;
  logic [1:0]            nxt_sync_q, nxt_sync_d;
  logic [1:0]            prv_sync_q, prv_sync_d;
  logic                  nxt_last_q, nxt_last_d;
  logic                  prv_last_q, prv_last_d;
  logic [PAGE_W-1:0]     page_q, page_d;
  logic [6:0]            seg_n_q, seg_n_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;

  logic                  tick;
  logic                  next_pulse;
  logic                  prev_pulse;
  logic [PAGE_W-1:0]     page_rev;
  logic [NIB_W-1:0]      nib_idx;
  logic [3:0]            nibble;
  logic [DIG_W-1:0]      slot;
  logic [NUM_DIGITS-1:0] an_sel_n;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned, which would infer a latch.
    scan_cnt_d  = scan_cnt_q + SCAN_DIV'(1);
    tick        = &scan_cnt_q;
    digit_idx_d = digit_idx_q;
    if (tick) begin
      digit_idx_d = (digit_idx_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_idx_q + DIG_W'(1);
    end

    done_d  = done_q;
    match_d = match_q;
    hash_d  = hash_q;
    if (bus.finished && !done_q) begin
      done_d  = 1'b1;
      match_d = (bus.hash_value == EXPECTED_HASH);
      hash_d  = bus.hash_value;
    end

    // Two-flop synchronizers followed by a rising-edge detector per button.
    nxt_sync_d = {nxt_sync_q[0], bus.page_next};
    prv_sync_d = {prv_sync_q[0], bus.page_prev};
    nxt_last_d = nxt_sync_q[1];
    prv_last_d = prv_sync_q[1];
    next_pulse = nxt_sync_q[1] & ~nxt_last_q;
    prev_pulse = prv_sync_q[1] & ~prv_last_q;

    page_d = page_q;
    if (next_pulse && !prev_pulse) begin
      page_d = (page_q == PAGE_W'(NUM_PAGES - 1)) ? '0 : page_q + PAGE_W'(1);
    end else if (prev_pulse && !next_pulse) begin
      page_d = (page_q == '0) ? PAGE_W'(NUM_PAGES - 1) : page_q - PAGE_W'(1);
    end

    // Page 0 holds the most-significant nibbles.
    page_rev = PAGE_W'(NUM_PAGES - 1) - page_q;
    nib_idx  = NIB_W'(page_rev) * NIB_W'(NUM_DIGITS) + NIB_W'(digit_idx_q);
    nibble   = hash_q[{nib_idx, 2'b00} +: 4];
    an_sel_n = ~(NUM_DIGITS'(1) << digit_idx_q);
    slot     = DIG_W'(NUM_DIGITS - 1) - digit_idx_q;

    seg_n_d = 7'h7F;
    an_n_d  = '1;
    if (done_q) begin
      if (bus.mode) begin
        seg_n_d = ~hex_font(nibble);
        an_n_d  = an_sel_n;
      end else begin
        an_n_d = an_sel_n;
        case (slot)
          DIG_W'(0): seg_n_d = ~(match_q ? LIT_P : LIT_F);
          DIG_W'(1): seg_n_d = ~LIT_A;
          DIG_W'(2): seg_n_d = ~(match_q ? LIT_S : LIT_I);
          DIG_W'(3): seg_n_d = ~(match_q ? LIT_S : LIT_L);
          default:   an_n_d  = '1;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scan_cnt_q  <= '0;
      digit_idx_q <= '0;
      done_q      <= 1'b0;
      match_q     <= 1'b0;
      // NOTE: the digest register is reset too, so a reset genuinely discards the stored result.
      hash_q      <= '0;
      nxt_sync_q  <= '0;
      prv_sync_q  <= '0;
      nxt_last_q  <= 1'b0;
      prv_last_q  <= 1'b0;
      page_q      <= '0;
      seg_n_q     <= 7'h7F;
      an_n_q      <= '1;
    end else begin
      scan_cnt_q  <= scan_cnt_d;
      digit_idx_q <= digit_idx_d;
      done_q      <= done_d;
      match_q     <= match_d;
      hash_q      <= hash_d;
      nxt_sync_q  <= nxt_sync_d;
      prv_sync_q  <= prv_sync_d;
      nxt_last_q  <= nxt_last_d;
      prv_last_q  <= prv_last_d;
      page_q      <= page_d;
      seg_n_q     <= seg_n_d;
      an_n_q      <= an_n_d;
    end
  end

  assign bus.seg_n     = seg_n_q;
  assign bus.an_n      = an_n_q;
  assign bus.done_LED  = done_q;
  assign bus.match_LED = match_q;
  assign bus.page      = page_q;
endmodule
